gan_host_loader: RTL

- Host-side initiator for the GAN core's load/start/readout interface.
- Accepts a valid/ready stream of parameter words in order: N_X inputs, then N_W weights, then N_B biases.
- Writes each word into the core's register file at sequential addresses starting at 0, then pulses start.
- Collects N_Y result words from the core's data_valid/data_out pair and re-emits them on a valid/ready output stream.

---
 rtl/gan_host_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/gan_host_loader.sv
// ============================================================================
// Module   : gan_host_loader
// Purpose  : Host-side initiator: streams N_X+N_W+N_B parameter words into the
//            GAN core register file, pulses start, then re-emits N_Y results.
//            Optional macro GAN_HOST_CHECKSUM_EN appends a modular-sum word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gan_host_loader #(
   parameter int WIDTH   = 28,
   parameter int N_X     = 4,
   parameter int N_W     = 54,
   parameter int N_B     = 19,
   parameter int N_Y     = 4,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       gan_addr,
   output logic [WIDTH-1:0] gan_data,
   output logic             gan_we,
   output logic             gan_start,
   input  logic [WIDTH-1:0] gan_data_out,
   input  logic             gan_data_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int N_TOT = N_X + N_W + N_B;
   localparam int CW    = 9;
   localparam int KW    = $clog2(N_Y + 2);
   localparam int KIW   = (N_Y > 1) ? $clog2(N_Y) : 1;
   localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
`ifdef GAN_HOST_CHECKSUM_EN
   localparam int N_OUT = N_Y + 1;
`else
   localparam int N_OUT = N_Y;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [KW-1:0]    k_q, k_d;
   logic [KW-1:0]    rd_q, rd_d;
   logic [TW-1:0]    wcnt_q, wcnt_d;
   logic [7:0]       addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             we_q, we_d;
   logic             start_q, start_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] rbuf_q [N_Y];
   logic             cap;

   // The final write cycle stays in LOAD but no longer accepts words.
   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_LOAD) && (cnt_q != CW'(N_TOT)));
   assign cap       = (state_q == S_WAIT) && gan_data_valid;
   assign gan_addr  = addr_q;
   assign gan_data  = wdata_q;
   assign gan_we    = we_q;
   assign gan_start = start_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign out_valid = (state_q == S_DRAIN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      rd_d    = rd_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      start_d = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               err_d   = 1'b0;
               we_d    = 1'b1;
               addr_d  = 8'd0;
               wdata_d = in_data;
               cnt_d   = CW'(1);
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (cnt_q == CW'(N_TOT)) begin
               start_d = 1'b1;
               state_d = S_START;
            end else if (in_valid) begin
               we_d    = 1'b1;
               addr_d  = cnt_q[7:0];
               wdata_d = in_data;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         S_START: begin
            k_d     = '0;
            rd_d    = '0;
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wcnt_d = wcnt_q + 1'b1;
            if (gan_data_valid) k_d = k_q + 1'b1;
            if (gan_data_valid && (k_q == KW'(N_Y - 1))) begin
               state_d = S_DRAIN;
            end else if ((TIMEOUT != 0) && (wcnt_q == TW'(TIMEOUT - 1))) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               rd_d = rd_q + 1'b1;
               if (rd_q == KW'(N_OUT - 1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         rd_q    <= '0;
         wcnt_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         rd_q    <= rd_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         start_q <= start_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Result storage needs no reset: it is only read in DRAIN after N_Y captures.
   always_ff @(posedge clk) begin
      if (cap) rbuf_q[k_q[KIW-1:0]] <= gan_data_out;
   end

`ifdef GAN_HOST_CHECKSUM_EN
   logic [WIDTH-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst || (state_q == S_START)) sum_q <= '0;
      else if (cap)                    sum_q <= sum_q + gan_data_out;
   end
`endif

   always_comb begin
      out_data = '0;
      if (state_q == S_DRAIN) begin
`ifdef GAN_HOST_CHECKSUM_EN
         if (rd_q == KW'(N_Y)) out_data = sum_q;
         else
`endif
         out_data = rbuf_q[rd_q[KIW-1:0]];
      end
   end

endmodule

`default_nettype wire
